// File: rtl/aes_key_schedule_ctrl_pkg.sv
// Shared definitions for the AES-128 key schedule controller.
//   - state_t: controller FSM encoding (IDLE, PRESENT, DONE)
//   - AES_NUM_ROUNDS_128: last round index for AES-128
//   - rot_word: RotWord word rotation
//   - gf_mul / sbox_byte: GF(2^8) arithmetic used to build the S-box
package aes_key_schedule_ctrl_pkg;

  localparam int AES_NUM_ROUNDS_128 = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // RotWord: rotate the word left by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (x^254, so 0 maps to 0) followed by
  // the affine transform. The inverse is the product x^2 * x^4 * ... * x^128.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int k = 0; k < 6; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One combinational step of AES-128 key expansion.
//   prev_key in  128 previous round key, [127:96] is w0
//   round    in  4   round index r (1..10) of the key being produced
//   next_key out 128 round key r, same word order
module aes_key_expand_step
  import aes_key_schedule_ctrl_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [3:0]   round,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon;
  logic [3:0]  rcon_idx;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  // Round r uses the constant at table index r-1.
  assign rcon_idx = round - 4'd1;

  round_constants u_rcon (
    .i    (rcon_idx),
    .rcon (rcon)
  );

  assign rot = rot_word(w3);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rot[8*b +: 8]),
      .dout (sub[8*b +: 8])
    );
  end

  assign t  = sub ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// Single-byte AES S-box (combinational).
//   din  in  8  input byte
//   dout out 8  substituted byte
module aes_sbox
  import aes_key_schedule_ctrl_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = sbox_byte(din);

endmodule

// File: rtl/round_constants.sv
// AES round constant lookup.
//   i    in  4  index 0..9 (round 1..10)
//   rcon out 8  round constant byte; 0 for unused indices
module round_constants (
  input  logic [3:0] i,
  output logic [7:0] rcon
);

  always_comb begin
    rcon = 8'h00;
    case (i)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 on-the-fly key schedule sequencer. Loads a cipher key on start and
// streams round keys 0..10 to the consumer, computing each from the previous.
//   clk       in  1   system clock, rising edge
//   rst       in  1   synchronous active-high reset
//   start     in  1   begin expansion of key_in (honoured only in IDLE)
//   key_in    in  128 cipher key, [127:96] is w0
//   rk_ready  in  1   consumer accepts the current round key
//   rk_valid  out 1   round_key / rk_round valid
//   round_key out 128 current round key
//   rk_round  out 4   round index of round_key
//   busy      out 1   high from accepted start through the done cycle
//   done      out 1   one-cycle pulse after round 10 is accepted
//
// Handshake: a round key transfers on a cycle where rk_valid && rk_ready at
// the rising edge. While rk_valid is high and rk_ready is low, round_key and
// rk_round are held unchanged; rk_valid never drops without a transfer.
module aes_key_schedule_ctrl
  import aes_key_schedule_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic             rk_ready,
  output logic             rk_valid,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       rk_round,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t           state, state_d;
  logic             load, advance;
  logic [3:0]       next_round;
  logic [KEY_W-1:0] step_key;

  // Rcon index derives from the registered rk_round, not from rk_ready.
  assign next_round = rk_round + 4'd1;

  aes_key_expand_step u_step (
    .prev_key (round_key),
    .round    (next_round),
    .next_key (step_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      round_key <= '0;
      rk_round  <= 4'd0;
    end else begin
      state <= state_d;
      if (load) begin
        round_key <= key_in;
        rk_round  <= 4'd0;
      end else if (advance) begin
        round_key <= step_key;
        rk_round  <= next_round;
      end
    end
  end

  always_comb begin
    state_d  = state;
    load     = 1'b0;
    advance  = 1'b0;
    rk_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        rk_valid = 1'b1;
        busy     = 1'b1;
        if (rk_ready) begin
          if (rk_round == LAST_ROUND) state_d = ST_DONE;
          else                        advance = 1'b1;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  a_round_range: assert property (@(posedge clk) disable iff (rst)
    rk_round <= 4'(AES_NUM_ROUNDS_128));

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
module tb_aes_key_schedule_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [127:0] fips_rk [0:10];

  aes_key_schedule_ctrl #(.NUM_ROUNDS(10), .KEY_W(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .rk_round  (rk_round),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard check
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks (called at a falling edge, return at the next falling edge)
  task automatic pulse_start(input logic [127:0] key);
    key_in = key;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (!(rk_valid === 1'b1 && rk_round === r) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_round_%0d", r), {127'd0, (rk_valid === 1'b1 && rk_round === r)}, 128'd1);
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_key",   round_key, 128'd0);
    chk("rst_round", {124'd0, rk_round}, 128'd0);
    chk("rst_busy",  {127'd0, busy}, 128'd0);
    chk("rst_done",  {127'd0, done}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 key, rk_ready held high: 11 back-to-back keys then done
    rk_ready = 1'b1;
    pulse_start(fips_rk[0]);
    for (int r = 0; r <= 10; r++) begin
      chk($sformatf("t1_valid_%0d", r), {127'd0, rk_valid}, 128'd1);
      chk($sformatf("t1_round_%0d", r), {124'd0, rk_round}, 128'(r));
      chk($sformatf("t1_key_%0d", r), round_key, fips_rk[r]);
      chk($sformatf("t1_busy_%0d", r), {127'd0, busy}, 128'd1);
      @(negedge clk);
    end
    chk("t1_done",       {127'd0, done}, 128'd1);
    chk("t1_done_valid", {127'd0, rk_valid}, 128'd0);
    chk("t1_done_busy",  {127'd0, busy}, 128'd1);
    @(negedge clk);
    chk("t1_idle_done",  {127'd0, done}, 128'd0);
    chk("t1_idle_busy",  {127'd0, busy}, 128'd0);
    chk("t1_idle_key",   round_key, fips_rk[10]);
    chk("t1_idle_round", {124'd0, rk_round}, 128'd10);

    // backpressure at round 3, ignored start at round 5
    pulse_start(fips_rk[0]);
    wait_round(4'd3);
    rk_ready = 1'b0;
    chk("bp_key_first", round_key, fips_rk[3]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_round_%0d", c), {124'd0, rk_round}, 128'd3);
      chk($sformatf("bp_key_%0d", c), round_key, fips_rk[3]);
      chk($sformatf("bp_valid_%0d", c), {127'd0, rk_valid}, 128'd1);
    end
    rk_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_round", {124'd0, rk_round}, 128'd4);
    chk("bp_release_key",   round_key, fips_rk[4]);
    wait_round(4'd5);
    pulse_start(128'h000102030405060708090a0b0c0d0e0f);
    chk("ign_round6", {124'd0, rk_round}, 128'd6);
    chk("ign_key6",   round_key, fips_rk[6]);
    chk("ign_busy",   {127'd0, busy}, 128'd1);
    wait_round(4'd9);
    chk("ign_key9", round_key, fips_rk[9]);
    @(negedge clk);
    chk("ign_key10", round_key, fips_rk[10]);
    @(negedge clk);
    chk("ign_done", {127'd0, done}, 128'd1);
    @(negedge clk);
    chk("ign_idle_busy", {127'd0, busy}, 128'd0);

    // reset mid-run at round 6
    pulse_start(fips_rk[0]);
    wait_round(4'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid", {127'd0, rk_valid}, 128'd0);
    chk("mrst_key",   round_key, 128'd0);
    chk("mrst_round", {124'd0, rk_round}, 128'd0);
    chk("mrst_busy",  {127'd0, busy}, 128'd0);
    chk("mrst_done",  {127'd0, done}, 128'd0);
    pulse_start(128'h000102030405060708090a0b0c0d0e0f);
    chk("k2_key0", round_key, 128'h000102030405060708090a0b0c0d0e0f);
    wait_round(4'd10);
    chk("k2_key10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    @(negedge clk);
    chk("k2_done", {127'd0, done}, 128'd1);
    @(negedge clk);

    // all-zero key; start in DONE cycle ignored, one cycle later accepted
    pulse_start(128'd0);
    wait_round(4'd10);
    @(negedge clk);
    chk("z_done", {127'd0, done}, 128'd1);
    key_in = 128'd0;
    start  = 1'b1;
    @(negedge clk);
    chk("z_ign_busy",  {127'd0, busy}, 128'd0);
    chk("z_ign_valid", {127'd0, rk_valid}, 128'd0);
    chk("z_ign_round", {124'd0, rk_round}, 128'd10);
    @(negedge clk);
    start = 1'b0;
    chk("z_acc_valid", {127'd0, rk_valid}, 128'd1);
    chk("z_acc_round", {124'd0, rk_round}, 128'd0);
    chk("z_acc_key",   round_key, 128'd0);
    @(negedge clk);
    chk("z_round1", {124'd0, rk_round}, 128'd1);
    chk("z_key1",   round_key, 128'h62636363626363636263636362636363);
    wait_round(4'd10);
    @(negedge clk);
    chk("z_end_done", {127'd0, done}, 128'd1);
    @(negedge clk);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
